// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: OFF/ON/BLINK/PWM with double-buffered config.
// Define LED_ACTIVE_LOW_EN to invert the led port for active-low boards.
module led_pwm_ctrl #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       enable,
   input  logic [2*NUM_CH-1:0]     cfg_mode,
   input  logic [CNT_W*NUM_CH-1:0] cfg_period,
   input  logic [CNT_W*NUM_CH-1:0] cfg_duty,
   input  logic [NUM_CH-1:0]       cfg_load,
   output logic [NUM_CH-1:0]       led,
   output logic [NUM_CH-1:0]       wrap_tick,
   output logic [NUM_CH-1:0]       cfg_pending
);

   localparam logic [1:0] M_OFF   = 2'd0;
   localparam logic [1:0] M_ON    = 2'd1;
   localparam logic [1:0] M_BLINK = 2'd2;
   localparam logic [1:0] M_PWM   = 2'd3;

`ifdef LED_ACTIVE_LOW_EN
   localparam logic POL = 1'b1;
`else
   localparam logic POL = 1'b0;
`endif

   logic [CNT_W-1:0]  r_cnt     [NUM_CH];
   logic [1:0]        r_mode    [NUM_CH];
   logic [CNT_W-1:0]  r_per     [NUM_CH];
   logic [CNT_W-1:0]  r_duty    [NUM_CH];
   logic [1:0]        r_sh_mode [NUM_CH];
   logic [CNT_W-1:0]  r_sh_per  [NUM_CH];
   logic [CNT_W-1:0]  r_sh_duty [NUM_CH];
   logic [NUM_CH-1:0] r_pend;
   logic [NUM_CH-1:0] r_led;
   logic [NUM_CH-1:0] r_wrap;

   logic [NUM_CH-1:0] w_run;
   logic [NUM_CH-1:0] w_wrap;
   logic [NUM_CH-1:0] w_apply;
   logic [NUM_CH-1:0] w_pend_nx;
   logic [NUM_CH-1:0] w_led_nx;
   logic [CNT_W-1:0]  w_last    [NUM_CH];
   logic [CNT_W-1:0]  w_cnt_nx  [NUM_CH];
   logic [1:0]        w_nmode   [NUM_CH];
   logic [CNT_W-1:0]  w_nper    [NUM_CH];
   logic [CNT_W-1:0]  w_nduty   [NUM_CH];
   logic [1:0]        w_emode   [NUM_CH];
   logic [CNT_W-1:0]  w_eduty   [NUM_CH];

   assign led         = r_led;
   assign wrap_tick   = r_wrap;
   assign cfg_pending = r_pend;

   // Per-channel counter, wrap, config-apply and next LED level (active-high)
   always_comb begin
      w_run     = '0;
      w_wrap    = '0;
      w_apply   = '0;
      w_pend_nx = '0;
      w_led_nx  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_run[i]   = enable[i] & r_mode[i][1];
         // Pe-1 with Pe = max(P,1); period 0 behaves as period 1
         w_last[i]  = (r_per[i] == '0) ? '0 : r_per[i] - 1'b1;
         w_wrap[i]  = w_run[i] & (r_cnt[i] == w_last[i]);
         w_apply[i] = (cfg_load[i] | r_pend[i]) & (~w_run[i] | w_wrap[i]);
         w_pend_nx[i] = (cfg_load[i] | r_pend[i]) & ~w_apply[i];
         // A load on the apply edge bypasses the shadow copy
         w_nmode[i] = cfg_load[i] ? cfg_mode[2*i +: 2]
                                  : r_sh_mode[i];
         w_nper[i]  = cfg_load[i] ? cfg_period[CNT_W*i +: CNT_W]
                                  : r_sh_per[i];
         w_nduty[i] = cfg_load[i] ? cfg_duty[CNT_W*i +: CNT_W]
                                  : r_sh_duty[i];
         w_emode[i] = w_apply[i] ? w_nmode[i] : r_mode[i];
         w_eduty[i] = w_apply[i] ? w_nduty[i] : r_duty[i];
         w_cnt_nx[i] = (~w_run[i] | w_wrap[i]) ? '0
                                               : r_cnt[i] + 1'b1;
         unique case (w_emode[i])
            M_OFF:   w_led_nx[i] = 1'b0;
            M_ON:    w_led_nx[i] = 1'b1;
            M_BLINK: w_led_nx[i] = w_run[i] &
                                   ((r_led[i] ^ POL) ^ w_wrap[i]);
            M_PWM:   w_led_nx[i] = w_run[i] &
                                   (r_cnt[i] < w_eduty[i]);
            default: w_led_nx[i] = 1'b0;
         endcase
      end
   end

   // Active/shadow config, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_cnt[i]     <= '0;
            r_mode[i]    <= M_OFF;
            r_per[i]     <= '0;
            r_duty[i]    <= '0;
            r_sh_mode[i] <= M_OFF;
            r_sh_per[i]  <= '0;
            r_sh_duty[i] <= '0;
         end
         r_pend <= '0;
         r_led  <= {NUM_CH{POL}};
         r_wrap <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_cnt[i] <= w_cnt_nx[i];
            if (w_apply[i]) begin
               r_mode[i] <= w_nmode[i];
               r_per[i]  <= w_nper[i];
               r_duty[i] <= w_nduty[i];
            end
            if (cfg_load[i]) begin
               r_sh_mode[i] <= cfg_mode[2*i +: 2];
               r_sh_per[i]  <= cfg_period[CNT_W*i +: CNT_W];
               r_sh_duty[i] <= cfg_duty[CNT_W*i +: CNT_W];
            end
         end
         r_pend <= w_pend_nx;
         r_led  <= w_led_nx ^ {NUM_CH{POL}};
         r_wrap <= w_wrap;
      end
   end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: directed scenarios plus random traffic,
// checked every cycle against an edge-count reference model.
module tb_led_pwm_ctrl;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 32;

`ifdef LED_ACTIVE_LOW_EN
   localparam logic POL = 1'b1;
`else
   localparam logic POL = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic [NUM_CH-1:0]       enable = '0;
   logic [2*NUM_CH-1:0]     cfg_mode = '0;
   logic [CNT_W*NUM_CH-1:0] cfg_period = '0;
   logic [CNT_W*NUM_CH-1:0] cfg_duty = '0;
   logic [NUM_CH-1:0]       cfg_load = '0;
   logic [NUM_CH-1:0]       led;
   logic [NUM_CH-1:0]       wrap_tick;
   logic [NUM_CH-1:0]       cfg_pending;

   int errors = 0;
   int checks = 0;

   led_pwm_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .cfg_mode(cfg_mode), .cfg_period(cfg_period),
      .cfg_duty(cfg_duty), .cfg_load(cfg_load),
      .led(led), .wrap_tick(wrap_tick), .cfg_pending(cfg_pending)
   );

   always #5 clk = ~clk;

   // Reference model: n = enabled counting edges since (re)start
   int          m_mode [NUM_CH];
   longint      m_P    [NUM_CH];
   longint      m_D    [NUM_CH];
   longint      m_n    [NUM_CH];
   int          s_mode [NUM_CH];
   longint      s_P    [NUM_CH];
   longint      s_D    [NUM_CH];
   logic [NUM_CH-1:0] m_led, m_wt, m_pend;

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_mode[i] = 0; m_P[i] = 0; m_D[i] = 0; m_n[i] = 0;
         s_mode[i] = 0; s_P[i] = 0; s_D[i] = 0;
      end
      m_led = '0; m_wt = '0; m_pend = '0;
   endtask

   function automatic longint pe_of(longint p);
      return (p == 0) ? 1 : p;
   endfunction

   task automatic model_step();
      for (int i = 0; i < NUM_CH; i++) begin
         bit run, wrap, ld, apply;
         longint pe, pos, nd;
         int nm, lm, lP, lD;
         run  = enable[i] && (m_mode[i] >= 2);
         pe   = pe_of(m_P[i]);
         pos  = m_n[i] % pe;
         wrap = run && (pos == pe - 1);
         ld   = cfg_load[i];
         apply = (ld || m_pend[i]) && (!run || wrap);
         lm = int'(cfg_mode[2*i +: 2]);
         lP = int'(cfg_period[CNT_W*i +: CNT_W]);
         lD = int'(cfg_duty[CNT_W*i +: CNT_W]);
         nm = apply ? (ld ? lm : s_mode[i]) : m_mode[i];
         nd = apply ? (ld ? longint'(lD) : s_D[i]) : m_D[i];
         if (nm == 0) m_led[i] = 1'b0;
         else if (nm == 1) m_led[i] = 1'b1;
         else if (!run) m_led[i] = 1'b0;
         else if (nm == 3) m_led[i] = (pos < nd);
         else if (wrap) m_led[i] = ~m_led[i];
         m_wt[i] = wrap;
         m_n[i]  = (!run || apply) ? 0 : m_n[i] + 1;
         if (apply) begin
            m_mode[i] = nm;
            m_P[i] = ld ? longint'(lP) : s_P[i];
            m_D[i] = nd;
         end
         if (ld) begin
            s_mode[i] = lm; s_P[i] = lP; s_D[i] = lD;
         end
         m_pend[i] = (ld || m_pend[i]) && !apply;
      end
   endtask

   function automatic logic [3*NUM_CH-1:0] exp_vec();
      return {m_led ^ {NUM_CH{POL}}, m_wt, m_pend};
   endfunction

   task automatic load(int ch, int mode, int p, int d);
      cfg_mode[2*ch +: 2] = 2'(mode);
      cfg_period[CNT_W*ch +: CNT_W] = CNT_W'(p);
      cfg_duty[CNT_W*ch +: CNT_W] = CNT_W'(d);
      cfg_load[ch] = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1 cfg_load = '0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      if ({led, wrap_tick, cfg_pending} !== {{NUM_CH{POL}}, 8'h00}) begin
         errors++;
         $display("FAIL reset_init got %b want %b",
                  {led, wrap_tick, cfg_pending}, {{NUM_CH{POL}}, 8'h00});
      end
      checks++;
      @(negedge clk) rst_n = 1'b1;
      enable[0] = 1'b1;
      load(0, 2, 5, 0);
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 6) load(0, 3, 7, 2);
      end
      if (cfg_pending[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_pend_set got %b want 1", cfg_pending[0]);
      end
      checks++;
      rst_n = 1'b0;
      #1 model_reset();
      if ({led, wrap_tick, cfg_pending} !== {{NUM_CH{POL}}, 8'h00}) begin
         errors++;
         $display("FAIL reset_async got %b want %b",
                  {led, wrap_tick, cfg_pending}, {{NUM_CH{POL}}, 8'h00});
      end
      checks++;
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (led[0] !== POL || {led, wrap_tick, cfg_pending} !== exp_vec())
         begin
            errors++;
            $display("FAIL reset_off cyc%0d got %b want %b", k,
                     {led, wrap_tick, cfg_pending}, exp_vec());
         end
         checks++;
      end
      enable[0] = 1'b0;
   endtask

   task automatic test_blink();
      logic [8:0] pat;
      pat = 9'b100011100;
      enable[1] = 1'b0;
      load(1, 2, 3, 0);
      tick();
      enable[1] = 1'b1;
      for (int k = 0; k < 9; k++) begin
         tick();
         if ((led[1] ^ POL) !== pat[k] ||
             wrap_tick[1] !== (k % 3 == 2) ||
             {led, wrap_tick, cfg_pending} !== exp_vec()) begin
            errors++;
            $display("FAIL blink_p3 cyc%0d got %b want %b", k,
                     {led, wrap_tick, cfg_pending}, exp_vec());
         end
         checks++;
      end
      load(1, 2, 0, 0);
      for (int k = 0; k < 10; k++) begin
         tick();
         if ({led, wrap_tick, cfg_pending} !== exp_vec()) begin
            errors++;
            $display("FAIL blink_p0 cyc%0d got %b want %b", k,
                     {led, wrap_tick, cfg_pending}, exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_pwm();
      int dl [3];
      dl = '{3, 0, 12};
      enable[2] = 1'b1;
      for (int t = 0; t < 3; t++) begin
         enable[2] = 1'b0;
         load(2, 3, 10, dl[t]);
         tick();
         enable[2] = 1'b1;
         for (int k = 0; k < 25; k++) begin
            tick();
            if ((led[2] ^ POL) !== ((k % 10) < dl[t]) ||
                {led, wrap_tick, cfg_pending} !== exp_vec()) begin
               errors++;
               $display("FAIL pwm_d%0d cyc%0d got %b want %b", dl[t], k,
                        {led, wrap_tick, cfg_pending}, exp_vec());
            end
            checks++;
         end
      end
   endtask

   task automatic test_update();
      bit found;
      enable[3] = 1'b0;
      load(3, 3, 8, 4);
      tick();
      enable[3] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k == 2) load(3, 3, 4, 1);
         tick();
         if ({led, wrap_tick, cfg_pending} !== exp_vec()) begin
            errors++;
            $display("FAIL update_pend cyc%0d got %b want %b", k,
                     {led, wrap_tick, cfg_pending}, exp_vec());
         end
         checks++;
      end
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         if ((m_n[3] % pe_of(m_P[3])) == pe_of(m_P[3]) - 1) begin
            found = 1;
            load(3, 3, 6, 2);
         end
         tick();
      end
      if (!found || cfg_pending[3] !== 1'b0 ||
          {led, wrap_tick, cfg_pending} !== exp_vec()) begin
         errors++;
         $display("FAIL update_on_wrap found=%0d got %b want %b", found,
                  {led, wrap_tick, cfg_pending}, exp_vec());
      end
      checks++;
      for (int k = 0; k < 12; k++) begin
         tick();
         if ({led, wrap_tick, cfg_pending} !== exp_vec()) begin
            errors++;
            $display("FAIL update_after cyc%0d got %b want %b", k,
                     {led, wrap_tick, cfg_pending}, exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_enable();
      enable[1] = 1'b0;
      load(1, 2, 4, 0);
      tick();
      enable[1] = 1'b1;
      for (int k = 0; k < 14; k++) begin
         if (k == 6) enable[1] = 1'b0;
         if (k == 8) enable[1] = 1'b1;
         if (k == 10) load(1, 3, 5, 2);
         if (k == 11) load(1, 2, 2, 0);
         tick();
         if ((k == 6 && (led[1] ^ POL) !== 1'b0) ||
             {led, wrap_tick, cfg_pending} !== exp_vec()) begin
            errors++;
            $display("FAIL enable cyc%0d got %b want %b", k,
                     {led, wrap_tick, cfg_pending}, exp_vec());
         end
         checks++;
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         if ({led, wrap_tick, cfg_pending} !== exp_vec()) begin
            errors++;
            $display("FAIL two_loads cyc%0d got %b want %b", k,
                     {led, wrap_tick, cfg_pending}, exp_vec());
         end
         checks++;
      end
      enable[0] = 1'b0;
      load(0, 1, 3, 0);
      tick();
      if ((led[0] ^ POL) !== 1'b1 ||
          {led, wrap_tick, cfg_pending} !== exp_vec()) begin
         errors++;
         $display("FAIL on_no_enable got %b want %b",
                  {led, wrap_tick, cfg_pending}, exp_vec());
      end
      checks++;
   endtask

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if ($urandom_range(15) == 0) enable[i] = ~enable[i];
            if ($urandom_range(9) == 0)
               load(i, int'($urandom_range(3)), int'($urandom_range(6)),
                    int'($urandom_range(8)));
         end
         tick();
         if ({led, wrap_tick, cfg_pending} !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc%0d got %b want %b", k,
                     {led, wrap_tick, cfg_pending}, exp_vec());
         end
         checks++;
      end
   endtask

   initial begin
      model_reset();
      #1;
      test_reset();
      test_blink();
      test_pwm();
      test_update();
      test_enable();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
